// File: rtl/gf8_itoh_tsuji_inv_if.sv
// Request/result bundle for the GF(2^8) inverter: start/operand in, busy/done/result out.
interface gf8_itoh_tsuji_inv_if;
  logic       start;
  logic [7:0] a_in;
  logic       busy;
  logic       done;
  logic [7:0] inv_out;

  modport master (output start, output a_in, input busy, input done, input inv_out);
  modport slave  (input start, input a_in, output busy, output done, output inv_out);
endinterface

// File: rtl/gf8_itoh_tsuji_inv.sv
// Sequential GF(2^8) inverter: a^-1 = a^254 via an Itoh-Tsuji chain of squarings and
// multiplications, one field operation per clock on a single shared multiplier.
module gf8_itoh_tsuji_inv #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input logic                 clk,
  input logic                 rst,
  gf8_itoh_tsuji_inv_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0] state;
  logic [3:0] step;
  logic [7:0] r_acc;
  logic [7:0] a_reg;
  logic [7:0] p_reg;
  logic [7:0] inv_q;
  logic       done_q;
  logic [7:0] mul_b;
  logic [7:0] prod;

  // Carry-less 8x8 product, then fold bits 14..8 back in MSB-first.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ ({7'b0, x} << i);
    end
    for (int i = 14; i >= 8; i--) begin
      if (p[i]) begin
        p    = p ^ ({7'b0, POLY} << (i - 8));
        p[i] = 1'b0;
      end
    end
    return p[7:0];
  endfunction

  // Second multiplier operand: A or the saved beta3 on multiply steps, else R (squaring).
  always_comb begin
    mul_b = r_acc;
    case (step)
      4'd2, 4'd4, 4'd10: mul_b = a_reg;
      4'd8:              mul_b = p_reg;
      default:           mul_b = r_acc;
    endcase
  end

  assign prod = gf_mul(r_acc, mul_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      step   <= '0;
      r_acc  <= '0;
      a_reg  <= '0;
      p_reg  <= '0;
      inv_q  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_reg <= bus.a_in;
            r_acc <= bus.a_in;
            step  <= 4'd1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= prod;
          if (step == 4'd4) p_reg <= prod;
          if (step == 4'd11) begin
            inv_q  <= prod;
            done_q <= 1'b1;
            step   <= '0;
            state  <= S_IDLE;
          end else begin
            done_q <= 1'b0;
            step   <= step + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == S_RUN);
  assign bus.done    = done_q;
  assign bus.inv_out = inv_q;

endmodule

// File: tb/tb_gf8_itoh_tsuji_inv.sv
// Randomized bench for gf8_itoh_tsuji_inv against a brute-force field-inverse model.
module tb_gf8_itoh_tsuji_inv;

  localparam logic [7:0] POLY = 8'h1B;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] last_inv;

  gf8_itoh_tsuji_inv_if bus ();

  gf8_itoh_tsuji_inv #(.POLY(POLY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Shift-and-xor multiply (xtime form), independent of any fixed-width product.
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc, xx, yy;
    acc = 8'h00; xx = x; yy = y;
    for (int k = 0; k < 8; k++) begin
      if (yy[0]) acc = acc ^ xx;
      xx = xx[7] ? ((xx << 1) ^ POLY) : (xx << 1);
      yy = yy >> 1;
    end
    return acc;
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (ref_mul(x, 8'(b)) == 8'h01) return 8'(b);
    end
    return 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one operation from a point just after an edge; returns in the done cycle.
  task automatic run_op(input logic [7:0] a, input bit noisy, input string tag);
    int cnt;
    logic [7:0] exp_inv;
    exp_inv = ref_inv(a);
    bus.start = 1'b1;
    bus.a_in  = a;
    tick();
    if (!noisy) bus.start = 1'b0;
    chk({tag, "_busy"}, 16'(bus.busy), 16'h1);
    chk({tag, "_done_lo"}, 16'(bus.done), 16'h0);
    cnt = 0;
    while (!bus.done && cnt < 30) begin
      if (!bus.done) chk({tag, "_held"}, 16'(bus.inv_out), 16'(last_inv));
      if (noisy) bus.a_in = 8'($urandom);
      tick();
      cnt++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 16'(cnt), 16'd11);
    chk({tag, "_inv"}, 16'(bus.inv_out), 16'(exp_inv));
    chk({tag, "_busy_end"}, 16'(bus.busy), 16'h0);
    last_inv = exp_inv;
  endtask

  initial begin
    int gap;
    bus.start = 1'b0;
    bus.a_in  = 8'h00;
    last_inv  = 8'h00;
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_done", 16'(bus.done), 16'h0);
    chk("rst_inv", 16'(bus.inv_out), 16'h00);
    rst = 1'b0;
    tick();

    run_op(8'h53, 1'b0, "v53");
    chk("v53_const", 16'(bus.inv_out), 16'hCA);
    tick();
    chk("v53_done_1cyc", 16'(bus.done), 16'h0);
    chk("v53_hold", 16'(bus.inv_out), 16'hCA);
    tick();

    // Back-to-back: each start goes in during the done cycle.
    run_op(8'h01, 1'b0, "v01");
    chk("v01_const", 16'(bus.inv_out), 16'h01);
    run_op(8'h02, 1'b0, "v02");
    chk("v02_const", 16'(bus.inv_out), 16'h8D);
    run_op(8'h03, 1'b0, "v03");
    chk("v03_const", 16'(bus.inv_out), 16'hF6);
    tick();

    run_op(8'h00, 1'b0, "zero");
    tick();

    // start held and a_in scrambled throughout the run.
    run_op(8'h53, 1'b1, "noisy");
    chk("noisy_const", 16'(bus.inv_out), 16'hCA);
    tick();
    chk("noisy_no_extra", 16'(bus.busy), 16'h0);

    // Abort mid-run: reset sampled on the edge that would execute step 6.
    bus.start = 1'b1;
    bus.a_in  = 8'h53;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 16'(bus.busy), 16'h0);
    chk("abort_done", 16'(bus.done), 16'h0);
    chk("abort_inv", 16'(bus.inv_out), 16'h00);
    rst = 1'b0;
    last_inv = 8'h00;
    tick();
    run_op(8'h02, 1'b0, "after_abort");
    chk("after_abort_const", 16'(bus.inv_out), 16'h8D);
    tick();

    // Full sweep with random idle gaps and random a_in noise between operations.
    for (int v = 1; v < 256; v++) begin
      run_op(8'(v), 1'b0, "sweep");
      chk("sweep_prod1", 16'(ref_mul(8'(v), bus.inv_out)), 16'h01);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        bus.a_in = 8'($urandom);
        tick();
        chk("sweep_gap_done", 16'(bus.done), 16'h0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
